config_monitor: RTL and testbench

CONFIG_MONITOR -- requirements
Module: config_monitor

---
 rtl/config_monitor.sv | 144 ++++++++++++++
 tb/tb_config_monitor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/config_monitor.sv
// config_monitor -- watches a one-hot frame-enable walk driven by a bitstream
// loader, accepts one frame per legal enable advance, folds the frame data
// into a running 32-bit checksum and flags protocol violations.
//
// Ports:
//   i_clock        sole clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_clear        synchronous restart to IDLE (counters, checksum, flags)
//   i_configs_en   one-hot frame enable from the loader
//   i_configs_in   frame data from the loader
//   i_ff_en        fabric flip-flop enable from the loader
//   i_chk_expected golden checksum
//   o_frame_strobe one-cycle pulse per accepted frame (registered)
//   o_frame_cnt    frames accepted
//   o_checksum     running checksum
//   o_done         all frames accepted (level)
//   o_chk_ok       done and checksum matches golden
//   o_err          sticky protocol violation
//   o_err_code     first violation: 0 none, 1 bad enable, 2 ff_en early,
//                  3 enable activity after done
module config_monitor #(
  parameter int FRAME_W    = 384,
  parameter int NUM_FRAMES = 267,
  localparam int CW        = $clog2(NUM_FRAMES + 1)
) (
  input  logic                  i_clock,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic [NUM_FRAMES-1:0] i_configs_en,
  input  logic [FRAME_W-1:0]    i_configs_in,
  input  logic                  i_ff_en,
  input  logic [31:0]           i_chk_expected,
  output logic                  o_frame_strobe,
  output logic [CW-1:0]         o_frame_cnt,
  output logic [31:0]           o_checksum,
  output logic                  o_done,
  output logic                  o_chk_ok,
  output logic                  o_err,
  output logic [1:0]            o_err_code
);

  localparam int NW = FRAME_W / 32;
  localparam logic [NUM_FRAMES-1:0] EN_FIRST = NUM_FRAMES'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_t;

  state_t                  r_state, w_state_n;
  logic [NUM_FRAMES-1:0]   r_en_q;
  logic [FRAME_W-1:0]      r_din_q;
  logic [CW-1:0]           r_cnt;
  logic [31:0]             r_cs;
  logic                    r_strobe;
  logic [1:0]              r_code;

  logic                    w_adv, w_legal, w_accept, w_set_err, w_en_zero;
  logic [1:0]              w_code;
  logic [31:0]             w_fold;

  // Delayed copies: an advance is seen when the live enable differs from the
  // previous cycle's, and the frame belongs to the data held under the old one.
  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      r_en_q  <= EN_FIRST;
      r_din_q <= '0;
    end else begin
      r_en_q  <= i_configs_en;
      r_din_q <= i_configs_in;
    end
  end

  assign w_adv     = (i_configs_en != r_en_q);
  // Shift out of the MSB yields zero, which marks the last frame.
  assign w_legal   = (i_configs_en == (r_en_q << 1));
  assign w_en_zero = (i_configs_en == '0);

  always_comb begin
    w_fold = '0;
    for (int i = 0; i < NW; i++) w_fold = w_fold ^ r_din_q[i*32 +: 32];
  end

  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    w_set_err = 1'b0;
    w_code    = 2'd0;
    case (r_state)
      S_IDLE, S_LOAD: begin
        if (i_ff_en) begin
          w_set_err = 1'b1;
          w_code    = 2'd2;
        end else if (w_adv && w_legal) begin
          w_accept  = 1'b1;
          w_state_n = w_en_zero ? S_DONE : S_LOAD;
        end else if (r_state == S_LOAD ? w_adv : (i_configs_en != EN_FIRST)) begin
          w_set_err = 1'b1;
          w_code    = 2'd1;
        end
      end
      S_DONE: begin
        if (!w_en_zero) begin
          w_set_err = 1'b1;
          w_code    = 2'd3;
        end
      end
      default: ;
    endcase
    if (w_set_err) w_state_n = S_ERROR;
  end

  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_cs     <= '0;
      r_strobe <= 1'b0;
      r_code   <= 2'd0;
    end else if (i_clear) begin
      // Clear wins over a same-cycle advance; that frame is dropped.
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_cs     <= '0;
      r_strobe <= 1'b0;
      r_code   <= 2'd0;
    end else begin
      r_state  <= w_state_n;
      r_strobe <= w_accept;
      if (w_accept) begin
        r_cnt <= r_cnt + CW'(1);
        r_cs  <= {r_cs[30:0], r_cs[31]} ^ w_fold;
      end
      // ERROR is terminal, so the first code recorded is never overwritten.
      if (w_set_err) r_code <= w_code;
    end
  end

  assign o_frame_strobe = r_strobe;
  assign o_frame_cnt    = r_cnt;
  assign o_checksum     = r_cs;
  assign o_done         = (r_state == S_DONE);
  assign o_chk_ok       = o_done && (r_cs == i_chk_expected);
  assign o_err          = (r_state == S_ERROR);
  assign o_err_code     = r_code;

endmodule

// File: tb/tb_config_monitor.sv
module tb_config_monitor;
  localparam int FW = 384;
  localparam int NF = 267;
  localparam int CW = $clog2(NF + 1);

  logic          clk = 1'b0;
  logic          rst, clear, ff_en;
  logic [NF-1:0] cfg_en;
  logic [FW-1:0] cfg_in;
  logic [31:0]   chk_exp;
  logic          strobe, done, chk_ok, err;
  logic [CW-1:0] fcnt;
  logic [31:0]   cs;
  logic [1:0]    ecode;

  always #5 clk = ~clk;

  config_monitor #(.FRAME_W(FW), .NUM_FRAMES(NF)) dut (
    .i_clock(clk), .i_rst(rst), .i_clear(clear), .i_configs_en(cfg_en),
    .i_configs_in(cfg_in), .i_ff_en(ff_en), .i_chk_expected(chk_exp),
    .o_frame_strobe(strobe), .o_frame_cnt(fcnt), .o_checksum(cs),
    .o_done(done), .o_chk_ok(chk_ok), .o_err(err), .o_err_code(ecode)
  );

  typedef struct packed {logic [CW-1:0] cnt; logic [31:0] cs;} exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0, nstrobe = 0;
  logic [31:0] m_cs;
  int          m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest predicted accept.
  always @(negedge clk) begin
    if (strobe === 1'b1) begin
      nstrobe++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_strobe: got cnt %0d expected no strobe", fcnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({fcnt, cs} !== e) begin
          errors++;
          $display("FAIL sb_accept: got cnt %0d cs %08h expected cnt %0d cs %08h",
                   fcnt, cs, e.cnt, e.cs);
        end
      end
    end
  end

  function automatic logic [31:0] fold(input logic [FW-1:0] d);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < FW/32; i++) f = f ^ d[i*32 +: 32];
    return f;
  endfunction

  function automatic logic [FW-1:0] data_of(input int mode, input int k);
    logic [FW-1:0] d;
    d = '0;
    if (mode == 1 && k == 0) d[0] = 1'b1;
    if (mode == 2)
      for (int j = 0; j < FW/32; j++)
        d[j*32 +: 32] = (k + 1) * 32'h9E3779B1 + j * 32'h01234567;
    return d;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_en(input int k);
    cfg_en = '0;
    if (k >= 0) cfg_en[k] = 1'b1;
    else if (k == -2) cfg_en[1:0] = 2'b11;
  endtask

  task automatic model_reset();
    m_cs = '0; m_cnt = 0; nstrobe = 0;
  endtask

  task automatic push_accept(input logic [FW-1:0] d);
    m_cs  = {m_cs[30:0], m_cs[31]} ^ fold(d);
    m_cnt = m_cnt + 1;
    sb.push_back({m_cnt[CW-1:0], m_cs});
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1; clear = 1'b0; ff_en = 1'b0; set_en(0); cfg_in = '0; chk_exp = '0;
    model_reset();
    #10 rst = 1'b0;
    tick(1);
  endtask

  // Walk enables from bit0 to bit 'last', cpf cycles each; leaving frame k-1
  // accepts it with the data that was held under it.
  task automatic load_to(input int mode, input int cpf, input int last);
    for (int k = 0; k <= last; k++) begin
      set_en(k);
      if (k > 0) push_accept(data_of(mode, k - 1));
      cfg_in = data_of(mode, k);
      tick(cpf);
    end
  endtask

  task automatic finish_load(input int mode);
    set_en(-1);
    cfg_in = '0;
    push_accept(data_of(mode, NF - 1));
    tick(2);
  endtask

  typedef struct {int en_idx; logic ff; logic e_err; logic [1:0] e_code; int e_cnt;} vec_t;
  vec_t vt[7];

  initial begin
    rst = 1'b1; clear = 1'b0; ff_en = 1'b0; cfg_en = '0; cfg_en[0] = 1'b1;
    cfg_in = '0; chk_exp = '0;
    model_reset();
    #1;
    chk("reset_cnt", 64'(fcnt), 0);
    chk("reset_flags", {60'd0, done, err, ecode}, 0);
    chk("reset_cs", 64'(cs), 0);
    #20 rst = 1'b0;
    tick(1);

    // One-cycle IDLE responses from a fresh reset.
    vt[0] = '{1,  1'b0, 1'b0, 2'd0, 0};
    vt[1] = '{1,  1'b0, 1'b0, 2'd0, 1};  // en index 1 = bit1: legal advance
    vt[2] = '{2,  1'b0, 1'b1, 2'd1, 0};  // skip to bit2
    vt[3] = '{-1, 1'b0, 1'b1, 2'd1, 0};  // zero early
    vt[4] = '{-2, 1'b0, 1'b1, 2'd1, 0};  // not one-hot
    vt[5] = '{0,  1'b1, 1'b1, 2'd2, 0};  // ff_en in IDLE
    vt[6] = '{1,  1'b1, 1'b1, 2'd2, 0};  // ff_en wins over advance
    vt[0].en_idx = 0;
    for (int i = 0; i < 7; i++) begin
      do_reset();
      cfg_in = data_of(2, i);
      tick(1);
      set_en(vt[i].en_idx); ff_en = vt[i].ff;
      if (vt[i].e_cnt == 1) push_accept(data_of(2, i));
      tick(1);
      ff_en = 1'b0;
      chk($sformatf("vec%0d_err", i), 64'(err), 64'(vt[i].e_err));
      chk($sformatf("vec%0d_code", i), 64'(ecode), 64'(vt[i].e_code));
      chk($sformatf("vec%0d_cnt", i), 64'(fcnt), 64'(vt[i].e_cnt));
      tick(1);
    end

    // Full zero load, two cycles per frame.
    do_reset();
    load_to(0, 2, NF - 1); finish_load(0);
    chk("zero_cnt", 64'(fcnt), NF);
    chk("zero_cs", 64'(cs), 0);
    chk("zero_done_ok_err", {61'd0, done, chk_ok, err}, 64'b110);
    chk("zero_strobes", 64'(nstrobe), NF);

    // Single set bit in frame 0 ends rotated by NF-1.
    do_reset();
    load_to(1, 1, NF - 1); finish_load(1);
    chk("bit_cs", 64'(cs), 64'h400);
    chk("bit_chk_ok0", 64'(chk_ok), 0);
    chk_exp = 32'h400; #1;
    chk("bit_chk_ok1", 64'(chk_ok), 1);

    // Skip bit4 -> bit6.
    do_reset();
    load_to(0, 1, 4);
    set_en(6); tick(3);
    chk("skip_code", {61'd0, err, ecode}, 64'b101);
    chk("skip_cnt", 64'(fcnt), 4);
    chk("skip_done", 64'(done), 0);

    // ff_en after frame 100, then a later illegal enable.
    do_reset();
    load_to(2, 2, 101);
    ff_en = 1'b1; tick(1); ff_en = 1'b0;
    chk("ff_code", {61'd0, err, ecode}, 64'b110);
    chk("ff_cnt", 64'(fcnt), 101);
    set_en(103); tick(2);
    chk("ff_code_sticky", 64'(ecode), 2);
    chk("ff_cs_hold", 64'(cs), 64'(m_cs));

    // Clear beats a same-cycle advance.
    do_reset();
    load_to(2, 3, 10);
    set_en(11); clear = 1'b1; tick(1);
    clear = 1'b0; set_en(0); tick(2);
    chk("clr_pri_cnt", 64'(fcnt), 0);
    chk("clr_pri_err_cs", {31'd0, err, cs}, 0);
    model_reset();

    // Activity after done, clear, then a fresh random load.
    load_to(2, 1, NF - 1); finish_load(2);
    chk("e_done", 64'(done), 1);
    set_en(0); tick(1);
    chk("after_done_code", {61'd0, err, ecode}, 64'b111);
    clear = 1'b1; tick(1); clear = 1'b0;
    chk("clear_outs", {cs, 24'd0, strobe, done, chk_ok, err, ecode, 2'd0}, 0);
    chk("clear_cnt", 64'(fcnt), 0);
    model_reset();
    load_to(2, 2, NF - 1); finish_load(2);
    chk_exp = m_cs; #1;
    chk("reload_done_ok", {61'd0, done, chk_ok, err}, 64'b110);
    chk("reload_cnt", 64'(fcnt), NF);

    // Asynchronous reset mid-frame 50.
    do_reset();
    load_to(0, 2, 50);
    chk("pre_rst_cnt", 64'(fcnt), 50);
    #2 rst = 1'b1; set_en(0); #1;
    chk("async_rst_outs", {cs, 26'd0, strobe, done, err, ecode, 1'b0}, 0);
    chk("async_rst_cnt", 64'(fcnt), 0);
    model_reset();
    tick(1); rst = 1'b0; tick(1);
    load_to(0, 2, NF - 1); finish_load(0);
    chk("rst_reload_cnt", 64'(fcnt), NF);
    chk("rst_reload_done", {62'd0, done, err}, 64'b10);

    tick(2);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
